// File: rtl/mda_hbridge_deadtime.sv
// H-bridge gate sequencer: turns an enable/direction/PWM command into the
// 4-bit gate word {fwd_top, fwd_bot, rev_top, rev_bot}. Every change between
// non-zero patterns passes through DEAD_CYCLES of all-off. A drive reversal
// first holds BRAKE until REV_HOLD_CYCLES non-drive cycles have elapsed.
module mda_hbridge_deadtime #(
    parameter int DEAD_CYCLES     = 25,
    parameter int REV_HOLD_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_in,
    input  logic       dir_in,
    input  logic       pwm_in,
    output logic [3:0] hb_out,
    output logic       dead_busy,
    output logic       drive_dir
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int RW = $clog2(REV_HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_V    = RW'(REV_HOLD_CYCLES);

    localparam logic [3:0] PAT_COAST = 4'b0000;
    localparam logic [3:0] PAT_FWD   = 4'b1001;
    localparam logic [3:0] PAT_REV   = 4'b0110;
    localparam logic [3:0] PAT_BRAKE = 4'b0101;

    typedef enum logic [1:0] {COAST_S, ON_S, DEAD_S} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cur_q, cur_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [RW-1:0]   rev_cnt_q, rev_cnt_d;
    logic            drive_dir_q, drive_dir_d;
    logic            en_q, dir_q, pwm_q;
    logic [3:0]      desired, eff;
    logic            des_drive, opposite;

    // Single register stage on the command inputs; everything below uses these.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q  <= 1'b0;
            dir_q <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            en_q  <= en_in;
            dir_q <= dir_in;
            pwm_q <= pwm_in;
        end
    end

    // Requested pattern, downgraded to BRAKE while a reversal is still locked out.
    always_comb begin
        if (!en_q)      desired = PAT_COAST;
        else if (pwm_q) desired = dir_q ? PAT_FWD : PAT_REV;
        else            desired = PAT_BRAKE;
        des_drive = (desired == PAT_FWD) || (desired == PAT_REV);
        opposite  = des_drive && ((desired == PAT_FWD) != drive_dir_q);
        eff       = (opposite && (rev_cnt_q < HOLD_V)) ? PAT_BRAKE : desired;
    end

    // Gate word and status are pure decodes of the state register.
    always_comb begin
        hb_out    = (state_q == ON_S) ? cur_q : PAT_COAST;
        dead_busy = (state_q == DEAD_S);
        drive_dir = drive_dir_q;
    end

    // Non-drive cycle counter: clears while driving, otherwise saturates at the hold.
    always_comb begin
        rev_cnt_d = rev_cnt_q;
        if ((hb_out == PAT_FWD) || (hb_out == PAT_REV))
            rev_cnt_d = '0;
        else if (rev_cnt_q != HOLD_V)
            rev_cnt_d = rev_cnt_q + 1'b1;
    end

    // Sequencer next state: the count is not restarted by eff changes in DEAD;
    // whatever eff is at expiry gets loaded.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        dcnt_d      = dcnt_q;
        drive_dir_d = drive_dir_q;
        case (state_q)
            COAST_S: begin
                if (eff != PAT_COAST) begin
                    state_d = DEAD_S;
                    dcnt_d  = '0;
                end
            end
            ON_S: begin
                if (eff == PAT_COAST) begin
                    state_d = COAST_S;
                end else if (eff != cur_q) begin
                    state_d = DEAD_S;
                    dcnt_d  = '0;
                end
            end
            DEAD_S: begin
                if (!en_q) begin
                    state_d = COAST_S;
                end else if (dcnt_q == DEAD_LAST) begin
                    if (eff != PAT_COAST) begin
                        state_d = ON_S;
                        cur_d   = eff;
                        if (eff == PAT_FWD) drive_dir_d = 1'b1;
                        if (eff == PAT_REV) drive_dir_d = 1'b0;
                    end else begin
                        state_d = COAST_S;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = COAST_S;
        endcase
    end

    // State registers; reset lets either direction drive immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COAST_S;
            cur_q       <= PAT_COAST;
            dcnt_q      <= '0;
            rev_cnt_q   <= HOLD_V;
            drive_dir_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            dcnt_q      <= dcnt_d;
            rev_cnt_q   <= rev_cnt_d;
            drive_dir_q <= drive_dir_d;
        end
    end

endmodule

// File: tb/tb_mda_hbridge_deadtime.sv
// Bench for mda_hbridge_deadtime: hand table for the start-up / PWM sequence,
// directed multi-cycle corner cases, then random commands against a
// countdown-style reference model plus gate-safety invariants.
module tb_mda_hbridge_deadtime;

    localparam int DC = 3;
    localparam int RH = 10;

    logic       clk = 1'b0;
    logic       reset, en_in, dir_in, pwm_in;
    logic [3:0] hb_out;
    logic       dead_busy, drive_dir;

    int checks = 0;
    int errors = 0;

    mda_hbridge_deadtime #(.DEAD_CYCLES(DC), .REV_HOLD_CYCLES(RH)) u_dut (
        .clk(clk), .reset(reset), .en_in(en_in), .dir_in(dir_in), .pwm_in(pwm_in),
        .hb_out(hb_out), .dead_busy(dead_busy), .drive_dir(drive_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r, e, d, p;
        logic [3:0] hb;
        bit busy, ddir;
    } vec_t;
    vec_t tbl[$];

    // reference model: registered command, current gate word, remaining dead cycles
    bit         m_en, m_dir, m_pwm, m_ddir;
    logic [3:0] m_out;
    int         m_dead_left, m_nd;

    // invariant trackers
    logic [3:0] last_nz, last_drv;
    int         zeros, gap;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit d, input bit p);
        logic [3:0] want, prev;
        if (r) begin
            m_en = 0; m_dir = 0; m_pwm = 0;
            m_out = 4'h0; m_dead_left = 0; m_ddir = 1; m_nd = RH;
        end else begin
            want = !m_en ? 4'h0 : (m_pwm ? (m_dir ? 4'h9 : 4'h6) : 4'h5);
            if (((want == 4'h9 && !m_ddir) || (want == 4'h6 && m_ddir)) && m_nd < RH)
                want = 4'h5;
            prev = m_out;
            if (m_dead_left > 0) begin
                if (!m_en) m_dead_left = 0;
                else if (m_dead_left == 1) begin
                    m_dead_left = 0;
                    m_out = want;
                    if (want == 4'h9) m_ddir = 1;
                    if (want == 4'h6) m_ddir = 0;
                end else m_dead_left--;
            end else if (want != m_out) begin
                m_out = 4'h0;
                if (want != 4'h0) m_dead_left = DC;
            end
            m_nd = (prev == 4'h9 || prev == 4'h6) ? 0 : (m_nd < RH ? m_nd + 1 : RH);
            m_en = e; m_dir = d; m_pwm = p;
        end
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cycle(input bit r, input bit e, input bit d, input bit p);
        reset = r; en_in = e; dir_in = d; pwm_in = p;
        @(posedge clk);
        model_step(r, e, d, p);
        @(negedge clk);
        chk("hb_model", int'(hb_out), int'(m_out));
        chk("busy_model", int'(dead_busy), int'(m_dead_left > 0));
        chk("dir_model", int'(drive_dir), int'(m_ddir));
        if (r) begin
            last_nz = 4'h0; last_drv = 4'h0; zeros = 0; gap = 0;
        end else begin
            chk("shoot_through", int'((hb_out[3] & hb_out[2]) | (hb_out[1] & hb_out[0])), 0);
            if (hb_out == 4'h0) zeros++;
            else begin
                if (last_nz != 4'h0 && hb_out != last_nz) chk("dead_gap", int'(zeros >= DC), 1);
                last_nz = hb_out; zeros = 0;
            end
            if (hb_out == 4'h9 || hb_out == 4'h6) begin
                if (last_drv != 4'h0 && hb_out != last_drv) chk("rev_gap", int'(gap >= RH), 1);
                last_drv = hb_out; gap = 0;
            end else gap++;
        end
    endtask

    task automatic run_until(input bit e, input bit d, input bit p, input logic [3:0] pat,
                             input int lim, output int n);
        n = 0;
        do begin
            cycle(0, e, d, p);
            n++;
        end while (hb_out != pat && n < lim);
    endtask

    task automatic add(input bit r, input bit e, input bit d, input bit p,
                       input logic [3:0] hb, input bit busy, input bit ddir);
        vec_t v;
        v.r = r; v.e = e; v.d = d; v.p = p; v.hb = hb; v.busy = busy; v.ddir = ddir;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit re, rd, rp, rr;
        reset = 1; en_in = 0; dir_in = 0; pwm_in = 0;
        m_en = 0; m_dir = 0; m_pwm = 0; m_out = 0; m_dead_left = 0; m_ddir = 1; m_nd = RH;
        last_nz = 0; last_drv = 0; zeros = 0; gap = 0;

        // start-up into FWD, PWM off to BRAKE, back on to FWD
        add(1,0,0,0, 4'h0,0,1);
        add(1,0,0,0, 4'h0,0,1);
        add(0,1,1,1, 4'h0,0,1);
        add(0,1,1,1, 4'h0,1,1);
        add(0,1,1,1, 4'h0,1,1);
        add(0,1,1,1, 4'h0,1,1);
        add(0,1,1,1, 4'h9,0,1);
        add(0,1,1,1, 4'h9,0,1);
        add(0,1,1,0, 4'h9,0,1);
        add(0,1,1,0, 4'h0,1,1);
        add(0,1,1,0, 4'h0,1,1);
        add(0,1,1,0, 4'h0,1,1);
        add(0,1,1,0, 4'h5,0,1);
        add(0,1,1,1, 4'h5,0,1);
        add(0,1,1,1, 4'h0,1,1);
        add(0,1,1,1, 4'h0,1,1);
        add(0,1,1,1, 4'h0,1,1);
        add(0,1,1,1, 4'h9,0,1);

        @(negedge clk);
        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].p);
            chk($sformatf("tbl%0d_hb", i), int'(hb_out), int'(tbl[i].hb));
            chk($sformatf("tbl%0d_busy", i), int'(dead_busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_dir", i), int'(drive_dir), int'(tbl[i].ddir));
        end

        // reversal: BRAKE hold, then dead time, then REV
        run_until(1, 0, 1, 4'h6, 200, n);
        chk("rev_latency", n, 3 + RH + DC);
        chk("rev_drive_dir", int'(drive_dir), 0);

        // enable dropped while ON: off after one registered cycle, no dead time
        cycle(0, 0, 0, 1);
        chk("en_off_hold", int'(hb_out), 6);
        cycle(0, 0, 0, 1);
        chk("en_off_hb", int'(hb_out), 0);
        chk("en_off_busy", int'(dead_busy), 0);
        run_until(1, 0, 1, 4'h6, 50, n);
        chk("reenable_latency", n, 2 + DC);

        // enable dropped inside DEAD
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        cycle(0, 1, 0, 1);
        chk("dead_en_busy", int'(dead_busy), 1);
        cycle(0, 0, 0, 1);
        chk("dead_en_reg", int'(dead_busy), 1);
        cycle(0, 0, 0, 1);
        chk("dead_en_drop_busy", int'(dead_busy), 0);
        chk("dead_en_drop_hb", int'(hb_out), 0);
        run_until(1, 0, 1, 4'h6, 50, n);
        chk("dead_reenable_latency", n, 2 + DC);

        // reset mid-DEAD from a REV history
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        cycle(0, 1, 0, 1);
        chk("rst_pre_busy", int'(dead_busy), 1);
        cycle(1, 1, 0, 1);
        chk("rst_mid_hb", int'(hb_out), 0);
        chk("rst_mid_busy", int'(dead_busy), 0);
        chk("rst_mid_dir", int'(drive_dir), 1);

        // pwm glitch inside a dead window: single dead period, FWD loaded
        cycle(0, 1, 1, 1);
        cycle(0, 1, 1, 1);
        chk("glitch_busy", int'(dead_busy), 1);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 1);
        chk("glitch_still_dead", int'(dead_busy), 1);
        cycle(0, 1, 1, 1);
        chk("glitch_load_hb", int'(hb_out), 9);
        chk("glitch_load_busy", int'(dead_busy), 0);

        // random commands, slowly varying so patterns actually get applied
        re = 1; rd = 1; rp = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 5) == 0) re = ~re;
            if ($urandom_range(0, 7) == 0) rd = ~rd;
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            rr = ($urandom_range(0, 499) == 0);
            cycle(rr, re, rd, rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
